shift_add_mul: RTL
==================

SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 Parameter W, default 4: operand width; product width is 2W.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 ld  input  1  load/start strobe, sampled on rising clk.
REQ-005 a  input  W  multiplicand.
REQ-006 b  input  W  multiplier.
REQ-007 ra  output  2W  accumulator register; holds the product when done.
REQ-008 rb  output  2W  shifted-multiplicand register.
REQ-009 ry  output  W  multiplier register, shifted right each step.
REQ-010 busy  output  1  high while iterating (state RUN).
REQ-011 done  output  1  high for exactly one cycle (state DONE).

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN, DONE and an internal step counter of width clog2(W)+1.
REQ-013 ld=1 at any edge, in any state, SHALL load: ra<=0; rb<={W zeros, a}; ry<=b; counter<=0; state<=RUN (ld has priority; an in-flight operation is abandoned).
REQ-014 In RUN with ld=0, each edge SHALL do: if ry[0]=1, ra<=ra+rb (2W-bit, no carry out); rb<=rb<<1 (zero fill); ry<=ry>>1 (zero fill); counter<=counter+1.
REQ-015 On the edge where counter reaches W-1 (the Wth step), state SHALL go to DONE.
REQ-016 Latency: ld sampled at edge 0 -> product valid in ra after edge W; done=1 from edge W to edge W+1; state IDLE after edge W+1.
REQ-017 From DONE with ld=0, state SHALL go to IDLE; ld=1 in DONE SHALL start a new operation and done SHALL be 0 in the following cycle.
REQ-018 In IDLE with ld=0, ra, rb, ry SHALL hold; the product stays in ra until the next ld or reset.
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; they SHALL never both be 1.
REQ-020 Unsigned product SHALL always fit 2W bits; no overflow flag exists.
REQ-021 b=0 or a=0 SHALL still take the full W steps and yield ra=0.

Reset
REQ-022 rst=0 SHALL immediately force ra=0, rb=0, ry=0, counter=0, state=IDLE, busy=0, done=0, independent of clk.
REQ-023 Reset during RUN SHALL abort the operation; no done pulse follows.
REQ-024 After rst rises, the block SHALL remain in IDLE until ld=1.

Configuration
REQ-025 Macro SHIFT_ADD_MUL_SIGNED_EN SHALL select two's-complement operands.
REQ-026 With the macro defined: on load, rb gets |a| and ry gets |b| (magnitudes as W-bit unsigned, so -2^(W-1) maps to 2^(W-1)), and a sign flag = a[W-1]^b[W-1] is registered; on the final RUN edge, ra SHALL be written as the negated sum if the flag is 1; latency stays per REQ-016.
REQ-027 Without the macro, operands are unsigned, no sign flag exists, and behaviour is exactly REQ-013..REQ-021.

Verification
REQ-028 Unsigned, W=4: ld with a=15, b=15 -> busy 4 cycles, done one cycle after edge 4, ra=8'hE1.
REQ-029 Unsigned: a=0, b=9 -> ra=8'h00 after 4 steps, done pulses once, then IDLE with ra held.
REQ-030 Restart: ld a=3,b=5; at edge 2 ld a=7,b=6 -> no done for the first operation; ra=8'h2A after edge 6, done during cycle 6-7.
REQ-031 Reset: ld a=9,b=9; drop rst mid-RUN -> all outputs 0 at once, no done; after release, ld a=2,b=3 -> ra=8'h06.
REQ-032 SIGNED_EN defined: a=4'b1101 (-3), b=5 -> ra=8'hF1; a=4'b1000, b=4'b1000 (-8*-8) -> ra=8'h40.
REQ-033 Back-to-back: ld held high during the DONE cycle -> new operation starts, done low in the next cycle, second result correct.

Source files
------------

// File: rtl/shift_add_mul_if.sv
// Operand/result bundle for shift_add_mul: the start strobe and operands
// enter through the slave side, and the working registers and status leave it.
interface shift_add_mul_if #(
  parameter int W = 4
);
  // ld is a fire-and-forget start strobe with no ready. Whenever ld is high
  // at a rising clk the operands a/b are taken and any running product is
  // dropped. done is a one-cycle valid for ra, and ra then holds until the
  // next ld. busy is high only while iterating.
  logic           ld;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] ra;
  logic [2*W-1:0] rb;
  logic [W-1:0]   ry;
  logic           busy;
  logic           done;

  modport master (
    output ld, a, b,
    input  ra, rb, ry, busy, done
  );

  modport slave (
    input  ld, a, b,
    output ra, rb, ry, busy, done
  );
endinterface

// File: rtl/shift_add_mul.sv
// Iterative shift-and-add multiplier: W steps per product, one bit of the multiplier per step.
// Define SHIFT_ADD_MUL_SIGNED_EN for two's-complement operands (sign-magnitude inside).
module shift_add_mul #(
  parameter int W = 4
) (
  input  logic                clk,
  input  logic                rst,
  shift_add_mul_if.slave      bus,
  output logic [1:0]          state_o
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [2*W-1:0]  ra_q;
  logic [2*W-1:0]  rb_q;
  logic [W-1:0]    ry_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;

  logic [W-1:0]    a_load;
  logic [W-1:0]    b_load;
  logic [2*W-1:0]  addend;
  logic [2*W-1:0]  step_sum;
  logic [2*W-1:0]  final_sum;
  logic            last_step;

  assign addend    = ry_q[0] ? rb_q : '0;
  assign step_sum  = ra_q + addend;
  assign last_step = (cnt_q == CNT_LAST);

`ifdef SHIFT_ADD_MUL_SIGNED_EN
  logic neg_q;

  // Magnitudes are taken as W-bit unsigned, so the most negative value maps
  // to 2^(W-1) and still fits; the sign is reapplied on the last step only.
  always_comb begin
    a_load = bus.a[W-1] ? (~bus.a + {{(W-1){1'b0}}, 1'b1}) : bus.a;
    b_load = bus.b[W-1] ? (~bus.b + {{(W-1){1'b0}}, 1'b1}) : bus.b;
  end

  assign final_sum = neg_q ? (~step_sum + {{(2*W-1){1'b0}}, 1'b1}) : step_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_q <= 1'b0;
    end else if (bus.ld) begin
      neg_q <= bus.a[W-1] ^ bus.b[W-1];
    end
  end
`else
  assign a_load    = bus.a;
  assign b_load    = bus.b;
  assign final_sum = step_sum;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      ry_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.ld) begin
      state_q <= RUN;
      ra_q    <= '0;
      rb_q    <= {{W{1'b0}}, a_load};
      ry_q    <= b_load;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          rb_q  <= rb_q << 1;
          ry_q  <= ry_q >> 1;
          cnt_q <= cnt_q + CNT_ONE;
          if (last_step) begin
            ra_q    <= final_sum;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            ra_q    <= step_sum;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ra   = ra_q;
  assign bus.rb   = rb_q;
  assign bus.ry   = ry_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign state_o  = state_q;

endmodule
